mc_datapath: RTL

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/cpu_pkg.sv | 6 +
 rtl/alu.sv | 26 ++
 rtl/regfile_p.sv | 21 ++
 rtl/mc_datapath.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU opcodes and multicycle FSM states shared by the datapath blocks.
package cpu_pkg;
    localparam int ALU_CONTROL_SIZE = 3;
    typedef enum logic [ALU_CONTROL_SIZE-1:0] {ADD, SUB, AND, OR, XOR, SLT, SLL, SRL} alu_op_e;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational XLEN-wide ALU with zero flag.
module alu import cpu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] y,
    output logic            zero
);
    localparam int SW = $clog2(XLEN);
    always_comb begin
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            SLT:     y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            SLL:     y = a << b[SW-1:0];
            SRL:     y = a >> b[SW-1:0];
            default: y = '0;
        endcase
    end
    assign zero = (y == '0);
endmodule

// File: rtl/regfile_p.sv
// regfile_p: two-read one-write register file; register 0 is hardwired to zero.
module regfile_p #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RW-1:0]   raddr1,
    input  logic [RW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] rf_q [NREGS];
    always_ff @(posedge clk)
        if (we && waddr != '0) rf_q[waddr] <= wdata;
    assign rdata1 = (raddr1 == '0) ? '0 : rf_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : rf_q[raddr2];
endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle CPU datapath with FETCH/DECODE/EXEC/MEM/WB control and a
// single unified memory port; decoding is done externally from instr.
module mc_datapath import cpu_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             RW       = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [RW-1:0]               rs1,
    input  logic [RW-1:0]               rs2,
    input  logic [RW-1:0]               rd,
    input  logic                        regWrite,
    input  logic                        memWrite,
    input  logic                        memRead,
    input  logic                        ALUSrc,
    input  logic                        branch,
    input  logic                        brNe,
    input  logic                        jump,
    input  logic [ALU_CONTROL_SIZE-1:0] ALUControl,
    input  logic [XLEN-1:0]             imm,
    output logic [31:0]                 instr,
    output logic [XLEN-1:0]             pc,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [XLEN-1:0]             mem_addr,
    output logic [XLEN-1:0]             mem_wdata,
    input  logic [XLEN-1:0]             mem_rdata,
    input  logic                        mem_ready,
    output logic                        retire
);
    localparam logic [XLEN-1:0] STEP = XLEN'(XLEN / 8);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] rs1_data, rs2_data, alu_y, rf_wdata, pc_step, pc_tgt;
    logic            alu_zero, rf_we;

    assign pc_step   = pc_q + STEP;
    assign pc_tgt    = pc_q + imm;
    assign rf_wdata  = memRead ? mdr_q : jump ? pc_step : alu_out_q;
    assign instr     = ir_q;
    assign pc        = pc_q;
    assign mem_wdata = b_q;

    alu #(.XLEN(XLEN)) u_alu (
        .a    (a_q),
        .b    (ALUSrc ? imm : b_q),
        .op   (alu_op_e'(ALUControl)),
        .y    (alu_y),
        .zero (alu_zero)
    );

    regfile_p #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        retire    = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rs1_data;
                b_d     = rs2_data;
                state_d = EXEC;
            end
            EXEC: begin
                alu_out_d = alu_y;
                if (branch) begin
                    pc_d    = (alu_zero ^ brNe) ? pc_tgt : pc_step;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (memRead || memWrite) begin
                    state_d = MEM;
                end else if (regWrite || jump) begin
                    state_d = WB;
                end else begin
                    pc_d    = pc_step;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_addr = alu_out_q;
                mem_we   = memWrite;
                if (mem_ready && memRead) begin
                    mdr_d   = mem_rdata;
                    state_d = WB;
                end else if (mem_ready) begin
                    pc_d    = pc_step;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                pc_d    = jump ? pc_tgt : pc_step;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Reset drops any in-flight request, so a mem_ready seen now cannot complete it.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
            rf_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q       <= a_d;
        b_q       <= b_d;
        alu_out_q <= alu_out_d;
        mdr_q     <= mdr_d;
    end
endmodule
